// File: rtl/mesh_lane_router_if.sv
// Bundled handshake and data signals of mesh_lane_router.
// Slot p*LANES+k carries port p (N,E,S,W,L) of lane k.
interface mesh_lane_router_if #(
   parameter int LANES  = 2,
   parameter int W      = 64,
   parameter int XW     = 2,
   parameter int YW     = 2,
   parameter int DROP_W = 8
);
   logic [5*LANES-1:0]    i_valid;
   logic [5*LANES*XW-1:0] i_dst_x;
   logic [5*LANES*YW-1:0] i_dst_y;
   logic [5*LANES*W-1:0]  i_payload;
   logic [5*LANES-1:0]    i_ready;
   logic [5*LANES-1:0]    o_valid;
   logic [5*LANES*XW-1:0] o_dst_x;
   logic [5*LANES*YW-1:0] o_dst_y;
   logic [5*LANES*W-1:0]  o_payload;
   logic [5*LANES-1:0]    o_ready;
   logic [LANES*DROP_W-1:0] o_drop_cnt;

   modport master (
      output i_valid, i_dst_x, i_dst_y, i_payload, o_ready,
      input  i_ready, o_valid, o_dst_x, o_dst_y, o_payload, o_drop_cnt
   );

   modport slave (
      input  i_valid, i_dst_x, i_dst_y, i_payload, o_ready,
      output i_ready, o_valid, o_dst_x, o_dst_y, o_payload, o_drop_cnt
   );
endinterface

// File: rtl/mesh_lane_router.sv
// Five-port XY mesh router node with independent lanes: per-port input FIFOs,
// round-robin output arbitration, single output register stage and drop counting.
module mesh_lane_router #(
   parameter int X_SIZE = 4,
   parameter int Y_SIZE = 4,
   parameter int X_IDX  = 0,
   parameter int Y_IDX  = 0,
   parameter int W      = 64,
   parameter int LANES  = 2,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input logic clk,
   input logic rst_n,
   mesh_lane_router_if.slave bus
);
   localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
   localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int EW = XW + YW + W;
   localparam int NP = 5;
   localparam logic [AW:0] PtrOne = 1;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [NP-1:0]     empty;
      logic [NP-1:0]     legal;
      logic [NP-1:0]     pop;
      logic [NP-1:0]     gnt;
      logic [2:0]        route [NP];
      logic [2:0]        win   [NP];
      logic [EW-1:0]     head  [NP];
      logic [2:0]        n_drop;
      logic [DROP_W+2:0] drop_sum;
      logic [DROP_W-1:0] drop_cnt_q;

      // Illegal heads leave without arbitration; granted heads leave with their output load.
      always_comb begin
         pop = ~empty & ~legal;
         for (int o = 0; o < NP; o++) begin
            if (gnt[o]) pop[win[o]] = 1'b1;
         end
      end

      always_comb begin
         n_drop = '0;
         for (int p = 0; p < NP; p++) begin
            n_drop = n_drop + {2'b00, ~empty[p] & ~legal[p]};
         end
         drop_sum = {3'b000, drop_cnt_q} + {{DROP_W{1'b0}}, n_drop};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            drop_cnt_q <= '0;
         end else if (drop_sum > {3'b000, {DROP_W{1'b1}}}) begin
            drop_cnt_q <= '1;
         end else begin
            drop_cnt_q <= drop_sum[DROP_W-1:0];
         end
      end

      assign bus.o_drop_cnt[k*DROP_W +: DROP_W] = drop_cnt_q;

      for (genvar p = 0; p < NP; p++) begin : g_in
         localparam int S = p * LANES + k;
         logic [AW:0]   wptr_q;
         logic [AW:0]   rptr_q;
         logic [EW-1:0] mem_q [DEPTH];
         logic          full;
         logic          push;
         logic [XW-1:0] hx;
         logic [YW-1:0] hy;

         assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
         assign empty[p] = (wptr_q == rptr_q);
         assign push     = bus.i_valid[S] && !full;
         assign bus.i_ready[S] = !full;

         assign head[p]  = mem_q[rptr_q[AW-1:0]];
         assign hx       = head[p][EW-1 -: XW];
         assign hy       = head[p][W +: YW];
         assign legal[p] = (int'(hx) < X_SIZE) && (int'(hy) < Y_SIZE);
         // Dimension-ordered: resolve the column first, then the row.
         assign route[p] = (int'(hx) > X_IDX) ? 3'd1 :
                           (int'(hx) < X_IDX) ? 3'd3 :
                           (int'(hy) > Y_IDX) ? 3'd2 :
                           (int'(hy) < Y_IDX) ? 3'd0 : 3'd4;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wptr_q <= '0;
               rptr_q <= '0;
            end else begin
               if (push)   wptr_q <= wptr_q + PtrOne;
               if (pop[p]) rptr_q <= rptr_q + PtrOne;
            end
         end

         always_ff @(posedge clk) begin
            if (push) begin
               mem_q[wptr_q[AW-1:0]] <= {bus.i_dst_x[S*XW +: XW], bus.i_dst_y[S*YW +: YW],
                                         bus.i_payload[S*W +: W]};
            end
         end
      end

      for (genvar o = 0; o < NP; o++) begin : g_out
         localparam int S = o * LANES + k;
         logic [2:0]    ptr_q;
         logic          vld_q;
         logic [EW-1:0] data_q;
         logic [NP-1:0] req;
         logic          found;
         logic [2:0]    sel;
         logic          load;

         always_comb begin
            req = '0;
            for (int p = 0; p < NP; p++) begin
               req[p] = ~empty[p] & legal[p] & (route[p] == 3'(o));
            end
            found = 1'b0;
            sel   = ptr_q;
            for (int i = 0; i < NP; i++) begin
               if (!found && req[(int'(ptr_q) + i) % NP]) begin
                  found = 1'b1;
                  sel   = 3'((int'(ptr_q) + i) % NP);
               end
            end
         end

         assign load    = !vld_q || bus.o_ready[S];
         assign gnt[o]  = found && load;
         assign win[o]  = sel;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ptr_q <= 3'd0;
               vld_q <= 1'b0;
            end else begin
               if (load)   vld_q <= found;
               if (gnt[o]) ptr_q <= (sel == 3'd4) ? 3'd0 : sel + 3'd1;
            end
         end

         always_ff @(posedge clk) begin
            if (gnt[o]) data_q <= head[sel];
         end

         assign bus.o_valid[S]             = vld_q;
         assign bus.o_dst_x[S*XW +: XW]    = data_q[EW-1 -: XW];
         assign bus.o_dst_y[S*YW +: YW]    = data_q[W +: YW];
         assign bus.o_payload[S*W +: W]    = data_q[W-1:0];
      end
   end
endmodule

// File: tb/tb_mesh_lane_router.sv
// Scoreboard bench for mesh_lane_router at node (1,1) of a 3x4 mesh: directed scenarios
// followed by randomized traffic, checked against a queue-based XY reference model.
module tb_mesh_lane_router;
   localparam int XS = 3, YS = 4, XI = 1, YI = 1;
   localparam int W = 16, L = 2, D = 4, DW = 2;
   localparam int XW = 2, YW = 2, NS = 5 * L;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [W-1:0]  pl;
   } pkt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mesh_lane_router_if #(.LANES(L), .W(W), .XW(XW), .YW(YW), .DROP_W(DW)) bus ();

   mesh_lane_router #(
      .X_SIZE(XS), .Y_SIZE(YS), .X_IDX(XI), .Y_IDX(YI),
      .W(W), .LANES(L), .DEPTH(D), .DROP_W(DW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // Expected packets per output slot, split by source port (per-source order is exact).
   pkt_t exp_q [NS][5][$];
   int   drops [L];
   int   l_log [$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   seq = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int ref_route(int x, int y);
      if (x >= XS || y >= YS) return -1;
      if (x > XI) return 1;
      if (x < XI) return 3;
      if (y > YI) return 2;
      if (y < YI) return 0;
      return 4;
   endfunction

   function automatic int total_left();
      int n = 0;
      for (int s = 0; s < NS; s++)
         for (int p = 0; p < 5; p++) n += exp_q[s][p].size();
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
      bus.i_valid = '0;
   endtask

   task automatic put(int p, int k, int x, int y);
      int   s;
      int   r;
      pkt_t pk;
      s = p * L + k;
      for (int i = 0; i < 50 && !bus.i_ready[s]; i++) step();
      check("put_ready", bus.i_ready[s], 1);
      if (bus.i_ready[s]) begin
         pk.x  = XW'(x);
         pk.y  = YW'(y);
         pk.pl = {3'(p), 1'(k), 12'(seq)};
         seq++;
         bus.i_valid[s] = 1'b1;
         bus.i_dst_x[s*XW +: XW] = pk.x;
         bus.i_dst_y[s*YW +: YW] = pk.y;
         bus.i_payload[s*W +: W] = pk.pl;
         r = ref_route(x, y);
         if (r < 0) drops[k]++;
         else exp_q[r*L+k][p].push_back(pk);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < NS; s++)
         for (int p = 0; p < 5; p++) exp_q[s][p].delete();
      for (int k = 0; k < L; k++) drops[k] = 0;
      l_log.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_model();
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic drain(int bound);
      bus.o_ready = '1;
      for (int i = 0; i < bound && total_left() != 0; i++) step();
      check("drain_left", total_left(), 0);
   endtask

   initial begin : monitor
      pkt_t          cur;
      pkt_t          e;
      int            src;
      logic [NS-1:0] held;
      pkt_t          held_pk [NS];
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = '0;
         end else begin
            for (int s = 0; s < NS; s++) begin
               cur.x  = bus.o_dst_x[s*XW +: XW];
               cur.y  = bus.o_dst_y[s*YW +: YW];
               cur.pl = bus.o_payload[s*W +: W];
               if (held[s]) begin
                  check("hold_valid", bus.o_valid[s], 1);
                  check("hold_data", cur, held_pk[s]);
               end
               held[s]    = bus.o_valid[s] && !bus.o_ready[s];
               held_pk[s] = cur;
               if (bus.o_valid[s] && bus.o_ready[s]) begin
                  src = int'(cur.pl[W-1 -: 3]);
                  if (s == 4 * L) l_log.push_back(src);
                  if (src < 5 && exp_q[s][src].size() > 0) begin
                     e = exp_q[s][src].pop_front();
                     check("sb_pkt", cur, e);
                  end else begin
                     n_chk++;
                     $display("FAIL sb_unexpected slot %0d: got packet 0x%0h, expected none",
                              s, cur);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      int rr_exp [7];
      int p, k, x, y;
      rr_exp = '{0, 1, 2, 3, 4, 0, 1};
      bus.i_valid = '0;
      bus.i_dst_x = '0;
      bus.i_dst_y = '0;
      bus.i_payload = '0;
      bus.o_ready = '1;
      clear_model();
      #1;
      check("rst_oval_async", bus.o_valid, 0);
      do_reset();
      @(negedge clk);
      check("rst_iready", bus.i_ready, {NS{1'b1}});
      check("rst_oval", bus.o_valid, 0);
      check("rst_drop", bus.o_drop_cnt, 0);
      step();

      // Local delivery latency
      put(4, 0, 1, 1);
      step();
      @(negedge clk);
      check("lat_t1", bus.o_valid[4*L], 0);
      @(negedge clk);
      check("lat_t2", bus.o_valid[4*L], 1);
      step();

      // XY ordering: (2,0) leaves E, (1,3) leaves S
      put(0, 0, 2, 0);
      step();
      put(0, 0, 1, 3);
      step();
      drain(30);

      // Round-robin on output L, lane 0
      do_reset();
      for (int i = 0; i < 4; i++) put(i, 0, 1, 1);
      step();
      for (int i = 0; i < 30 && l_log.size() < 4; i++) step();
      put(4, 0, 1, 1);
      put(0, 0, 1, 1);
      put(1, 0, 1, 1);
      step();
      for (int i = 0; i < 30 && l_log.size() < 7; i++) step();
      check("rr_count", l_log.size(), 7);
      for (int i = 0; i < 7 && i < l_log.size(); i++) check("rr_order", l_log[i], rr_exp[i]);
      drain(30);

      // Backpressure on E lane 0 fed from W lane 0
      bus.o_ready[1*L+0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         put(3, 0, 2, 1);
         step();
      end
      @(negedge clk);
      check("bp_iready_low", bus.i_ready[3*L+0], 0);
      check("bp_oval", bus.o_valid[1*L+0], 1);
      step();
      step();
      step();
      drain(40);

      // Drop counting and saturation on lane 1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         put(0, 1, 3, 0);
         step();
         step();
         @(negedge clk);
         check("drop_cnt", bus.o_drop_cnt[1*DW +: DW], (i < 3) ? i + 1 : 3);
         check("drop_lane0", bus.o_drop_cnt[0 +: DW], 0);
         check("drop_noval", bus.o_valid, 0);
         step();
      end

      // Reset while buffers hold traffic
      bus.o_ready = '0;
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < NS; s++) put(s / L, s % L, $urandom_range(2), $urandom_range(3));
         step();
      end
      @(negedge clk);
      check("mid_busy", |bus.o_valid, 1);
      step();
      rst_n = 1'b0;
      clear_model();
      #1;
      check("mid_oval_async", bus.o_valid, 0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_iready", bus.i_ready, {NS{1'b1}});
      check("mid_drop", bus.o_drop_cnt, 0);
      step();

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int s = 0; s < NS; s++) bus.o_ready[s] = ($urandom_range(3) != 0);
         for (int s = 0; s < NS; s++) begin
            if ($urandom_range(1) == 1) begin
               p = s / L;
               k = s % L;
               x = ($urandom_range(7) == 0) ? 3 : $urandom_range(2);
               y = $urandom_range(3);
               if (bus.i_ready[s]) begin
                  put(p, k, x, y);
               end else begin
                  bus.i_valid[s] = 1'b1;
                  bus.i_dst_x[s*XW +: XW] = XW'($urandom);
                  bus.i_dst_y[s*YW +: YW] = YW'($urandom);
                  bus.i_payload[s*W +: W] = W'($urandom);
               end
            end
         end
         step();
      end
      drain(300);
      step();
      @(negedge clk);
      for (int kk = 0; kk < L; kk++) begin
         check("rand_drop", bus.o_drop_cnt[kk*DW +: DW], (drops[kk] > 3) ? 3 : drops[kk]);
      end
      check("end_idle", bus.o_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
